counter_mux_sel_ctrl: RTL and testbench

//  Sequencer for the per-channel source selects of the counter data-mux/synchroniser array.

---
 rtl/counter_mux_sel_ctrl.sv | 158 +++++++++++++++
 tb/tb_counter_mux_sel_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/counter_mux_sel_ctrl.sv
// rtl/counter_mux_sel_ctrl.sv - round-robin sequencer for per-channel mux selects of the counter mux-sync array
// Applies select changes one channel at a time, blanking that channel's valid flag while its path settles.
module counter_mux_sel_ctrl #(
  parameter int COUNTER_NUM = 4,
  parameter int SETTLE_CYC  = 4,
  parameter int CNT_W       = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [COUNTER_NUM-1:0] i_req,
  input  logic [COUNTER_NUM-1:0] i_req_sel,
  output logic [COUNTER_NUM-1:0] o_mux_sel,
  output logic [COUNTER_NUM-1:0] o_ch_valid,
  output logic [COUNTER_NUM-1:0] o_ack,
  output logic                   o_busy
);

  localparam int                IDX_W    = (COUNTER_NUM > 1) ? $clog2(COUNTER_NUM) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_BLANK,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t                 state_q,    state_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic [COUNTER_NUM-1:0] pending_q,  pending_d;
  logic [COUNTER_NUM-1:0] target_q,   target_d;
  logic [COUNTER_NUM-1:0] mux_sel_q,  mux_sel_d;
  logic [COUNTER_NUM-1:0] ch_valid_q, ch_valid_d;
  logic [COUNTER_NUM-1:0] ack_q,      ack_d;
  logic [IDX_W-1:0]       rr_q,       rr_d;
  logic [IDX_W-1:0]       gnt_q,      gnt_d;

  logic                   any_pend;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick;
  logic [IDX_W-1:0]       pick_next;
  int                     arb_idx;

  assign any_pend = |pending_q;

  // Round robin: first pending channel at or after the pointer, wrapping.
  always_comb begin
    pick       = rr_q;
    pick_found = 1'b0;
    arb_idx    = 0;
    for (int k = 0; k < COUNTER_NUM; k++) begin
      arb_idx = int'(rr_q) + k;
      if (arb_idx >= COUNTER_NUM) begin
        arb_idx = arb_idx - COUNTER_NUM;
      end
      if (!pick_found && pending_q[arb_idx]) begin
        pick       = IDX_W'(arb_idx);
        pick_found = 1'b1;
      end
    end
    pick_next = (int'(pick) == COUNTER_NUM - 1) ? '0 : pick + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    target_d   = target_q;
    mux_sel_d  = mux_sel_q;
    ch_valid_d = ch_valid_q;
    ack_d      = ack_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == '0) begin
          state_d    = ST_IDLE;
          ch_valid_d = '1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_IDLE: begin
        if (any_pend) begin
          gnt_d            = pick;
          pending_d[pick]  = 1'b0;
          rr_d             = pick_next;
          // A request that matches the current select needs no blanking.
          if (target_q[pick] == mux_sel_q[pick]) begin
            state_d     = ST_DONE;
            ack_d[pick] = 1'b1;
          end else begin
            state_d          = ST_BLANK;
            ch_valid_d[pick] = 1'b0;
          end
        end
      end
      ST_BLANK: begin
        mux_sel_d[gnt_q] = target_q[gnt_q];
        cnt_d            = CNT_INIT;
        state_d          = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d           = ST_DONE;
          ch_valid_d[gnt_q] = 1'b1;
          ack_d[gnt_q]      = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        ack_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = CNT_INIT;
      end
    endcase

    // New requests land after the grant so a re-request of the granted channel stays pending.
    pending_d = pending_d | i_req;
    target_d  = (target_q & ~i_req) | (i_req_sel & i_req);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= CNT_INIT;
      pending_q  <= '0;
      target_q   <= '0;
      mux_sel_q  <= '0;
      ch_valid_q <= '0;
      ack_q      <= '0;
      rr_q       <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      target_q   <= target_d;
      mux_sel_q  <= mux_sel_d;
      ch_valid_q <= ch_valid_d;
      ack_q      <= ack_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
    end
  end

  assign o_mux_sel  = mux_sel_q;
  assign o_ch_valid = ch_valid_q;
  assign o_ack      = ack_q;
  assign o_busy     = (state_q != ST_IDLE) | any_pend;

endmodule

// File: tb/tb_counter_mux_sel_ctrl.sv
// tb/tb_counter_mux_sel_ctrl.sv - randomized self-checking bench for counter_mux_sel_ctrl
// Reference model schedules each service as timed events from the grant cycle.
module tb_counter_mux_sel_ctrl;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_sel = '0;
  logic [N-1:0] o_mux_sel;
  logic [N-1:0] o_ch_valid;
  logic [N-1:0] o_ack;
  logic         o_busy;

  counter_mux_sel_ctrl #(
    .COUNTER_NUM (N),
    .SETTLE_CYC  (S),
    .CNT_W       (CW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_req_sel  (req_sel),
    .o_mux_sel  (o_mux_sel),
    .o_ch_valid (o_ch_valid),
    .o_ack      (o_ack),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: edge count since reset release, plus the scheduled edges of the current service.
  logic [N-1:0] m_sel, m_valid, m_pend, m_tgt, m_ack;
  int           c, rr, grant_ok, sel_at, done_at, svc_ch;
  bit           svc_active;

  task automatic model_reset();
    c          = 0;
    m_sel      = '0;
    m_valid    = '0;
    m_pend     = '0;
    m_tgt      = '0;
    m_ack      = '0;
    rr         = 0;
    grant_ok   = S + 1;
    svc_active = 0;
    sel_at     = 0;
    done_at    = 0;
    svc_ch     = 0;
  endtask

  task automatic model_edge();
    int g;
    c++;
    m_ack = '0;
    if (svc_active && c == sel_at) m_sel[svc_ch] = m_tgt[svc_ch];
    if (svc_active && c == done_at) begin
      m_valid[svc_ch] = 1'b1;
      m_ack[svc_ch]   = 1'b1;
      svc_active      = 0;
    end
    if (c == S) m_valid = '1;
    if (c >= grant_ok && m_pend != '0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(rr + k) % N]) g = (rr + k) % N;
      end
      m_pend[g] = 1'b0;
      rr        = (g + 1) % N;
      if (m_tgt[g] == m_sel[g]) begin
        m_ack[g] = 1'b1;
        grant_ok = c + 2;
      end else begin
        m_valid[g] = 1'b0;
        svc_active = 1;
        svc_ch     = g;
        sel_at     = c + 1;
        done_at    = c + S + 1;
        grant_ok   = c + S + 3;
      end
    end
    m_pend = m_pend | req;
    m_tgt  = (m_tgt & ~req) | (req & req_sel);
  endtask

  task automatic check_outputs();
    check_eq("mux_sel",  32'(o_mux_sel),  32'(m_sel));
    check_eq("ch_valid", 32'(o_ch_valid), 32'(m_valid));
    check_eq("ack",      32'(o_ack),      32'(m_ack));
    check_eq("busy",     32'(o_busy),     32'((c + 1 < grant_ok) || (m_pend != '0)));
  endtask

  task automatic check_in_reset();
    check_eq("rst_mux_sel",  32'(o_mux_sel),  32'd0);
    check_eq("rst_ch_valid", 32'(o_ch_valid), 32'd0);
    check_eq("rst_ack",      32'(o_ack),      32'd0);
    check_eq("rst_busy",     32'(o_busy),     32'd1);
  endtask

  task automatic drive_inputs(input int cyc, input int n_rst);
    logic [31:0] r;
    if (n_rst == 0 && cyc == S + 2) begin
      req     = '1;
      req_sel = '1;
    end else if (n_rst == 0 && (cyc == S + 40 || cyc == S + 41)) begin
      req     = 4'b0100;
      req_sel = (cyc == S + 40) ? 4'b0000 : 4'b0100;
    end else begin
      r = (cyc % 400 < 200) ? ($urandom & $urandom & $urandom) : ($urandom & $urandom & $urandom & $urandom & $urandom & $urandom);
      req     = r[N-1:0];
      r       = $urandom;
      req_sel = r[N-1:0];
    end
  endtask

  initial begin
    int n_rst;
    bit do_rst;
    n_rst = 0;
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    check_in_reset();
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
      do_rst = (cyc >= 900  && n_rst == 0 && ((svc_active && c > sel_at) || cyc >= 1100)) ||
               (cyc >= 2000 && n_rst == 1 && ((svc_active && c > sel_at) || cyc >= 2200));
      if (do_rst) begin
        n_rst++;
        rst = 1'b1;
        req = '0;
        #1;
        check_in_reset();
        @(negedge clk);
        check_in_reset();
        rst = 1'b0;
        model_reset();
      end else begin
        drive_inputs(cyc, n_rst);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
